// File: rtl/three_in_debounce.sv
// Three-channel switch debouncer: 2-flop synchronizer plus a STABLE/CHECK FSM per channel.
// Optional per-channel change pulse `chg` is built only when THREE_DEB_EDGE_EN is defined.
module three_in_debounce #(
  parameter int DEB_LEN = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] raw,
  output logic [2:0] x,
  output logic       stable
`ifdef THREE_DEB_EDGE_EN
  ,
  output logic [2:0] chg
`endif
);

  typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

  logic [2:0] s1_reg;
  logic [2:0] s2_reg;
  logic [2:0] in_check;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             x_reg;
    logic             load;

    // The new level has now been seen on DEB_LEN consecutive s2 samples.
    assign load = (state_reg == CHECK) && (s2_reg[gi] != x_reg) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= STABLE;
        cnt_reg   <= '0;
        x_reg     <= 1'b0;
      end else begin
        case (state_reg)
          STABLE: begin
            if (s2_reg[gi] != x_reg) begin
              state_reg <= CHECK;
              cnt_reg   <= CNT_W'(1);
            end else begin
              cnt_reg <= '0;
            end
          end
          CHECK: begin
            if (s2_reg[gi] == x_reg) begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end else if (load) begin
              x_reg     <= s2_reg[gi];
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end

    assign x[gi]        = x_reg;
    assign in_check[gi] = (state_reg == CHECK);

`ifdef THREE_DEB_EDGE_EN
    logic chg_reg;

    // Registered alongside x_reg so the pulse lines up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chg_reg <= 1'b0;
      else        chg_reg <= load;
    end

    assign chg[gi] = chg_reg;
`endif
  end

  assign stable = ~|in_check;

endmodule
